aes256_dec_core: RTL and testbench

//  Iterative AES-256 decryptor: the inverse of the encryption datapath.

---
 rtl/aes_dec_pkg.sv | 59 +++++
 rtl/aes_inv_sbox.sv | 28 ++
 rtl/aes256_dec_core.sv | 154 +++++++++++++++
 tb/tb_aes256_dec_core.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_dec_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-256 decryptor.
package aes_dec_pkg;

    localparam int NR     = 14;
    localparam int N      = 16;
    localparam int WORD_W = 32;
    localparam int RK_W   = $clog2(NR + 1);
    localparam logic [RK_W-1:0] LAST_RND = RK_W'(NR);

    // Byte i lives at [8*i +: 8]; byte 4*col + row (column-major).
    typedef logic [N-1:0][7:0] state_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KREQ,
        ST_ARK,
        ST_IMIX,
        ST_ISHIFT,
        ST_ISUB,
        ST_FIN
    } dec_st_e;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    function automatic state_t inv_shift_rows(input state_t s);
        state_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[4*((c + r) % 4) + r] = s[4*c + r];
        return o;
    endfunction

    function automatic state_t inv_mix_columns(input state_t s);
        state_t     o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[4*c];
            a1 = s[4*c + 1];
            a2 = s[4*c + 2];
            a3 = s[4*c + 3];
            o[4*c]     = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[4*c + 1] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[4*c + 2] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[4*c + 3] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational 256x8 AES inverse S-box ROM, one byte per lookup.
module aes_inv_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign o_byte = INV_SBOX[i_byte];

endmodule

// File: rtl/aes256_dec_core.sv
// Iterative AES-256 decryptor: bus-loaded ciphertext, round keys pulled from an external ROM.
// Optional sticky error flag on misuse is enabled with `define AES_DEC_ERR_EN.
module aes256_dec_core
    import aes_dec_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                addr,
    input  logic [WORD_W-1:0]   data_in,
    input  logic                req_axi_in,
    output logic [RK_W-1:0]     rk_sel,
    input  logic [N*8-1:0]      rk_data,
    output logic                busy,
    output logic                done,
`ifdef AES_DEC_ERR_EN
    output logic                err,
`endif
    output logic [N*8-1:0]      decData
);

    dec_st_e          r_st, w_st_nxt;
    logic [1:0]       r_wr_ptr;
    logic             r_full;
    logic [RK_W-1:0]  r_round;
    logic [RK_W-1:0]  r_rk_sel;
    logic [3:0]       r_cnt;
    logic             r_done;
    state_t           r_dec;
    state_t           r_ct;
    state_t           r_state;
    logic [7:0]       w_sub_out;
    logic             w_idle, w_ct_wr, w_ctl_wr, w_clr, w_accept;

    assign w_idle   = (r_st == ST_IDLE);
    assign w_ct_wr  = w_idle & req_axi_in & addr;
    assign w_ctl_wr = w_idle & req_axi_in & ~addr;
    assign w_clr    = w_ctl_wr & data_in[1];
    assign w_accept = w_ctl_wr & data_in[0] & ~data_in[1] & r_full;

    // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_st_nxt = r_st;
        case (r_st)
            ST_IDLE:   if (w_accept) w_st_nxt = ST_KREQ;
            ST_KREQ:   w_st_nxt = ST_ARK;
            ST_ARK: begin
                if (r_round == LAST_RND)   w_st_nxt = ST_ISHIFT;
                else if (r_round == '0)    w_st_nxt = ST_FIN;
                else                       w_st_nxt = ST_IMIX;
            end
            ST_IMIX:   w_st_nxt = ST_ISHIFT;
            ST_ISHIFT: w_st_nxt = ST_ISUB;
            ST_ISUB:   if (r_cnt == 4'd15) w_st_nxt = ST_KREQ;
            ST_FIN:    w_st_nxt = ST_IDLE;
            default:   w_st_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) r_st <= ST_IDLE;
        else        r_st <= w_st_nxt;
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_wr_ptr <= 2'd0;
            r_full   <= 1'b0;
            r_round  <= '0;
            r_rk_sel <= '0;
            r_cnt    <= 4'd0;
            r_done   <= 1'b0;
            r_dec    <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_ct_wr) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
                if (r_wr_ptr == 2'd3) r_full <= 1'b1;
            end
            if (w_clr) begin
                r_wr_ptr <= 2'd0;
                r_full   <= 1'b0;
            end
            case (r_st)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_round  <= LAST_RND;
                        r_rk_sel <= LAST_RND;
                    end
                end
                ST_ARK:  if (r_round == LAST_RND) r_round <= r_round - 1'b1;
                ST_IMIX: r_round <= r_round - 1'b1;
                ST_ISUB: begin
                    r_cnt <= r_cnt + 4'd1;
                    // The key index moves only on entry to KREQ; the ROM then has a cycle to respond.
                    if (r_cnt == 4'd15) r_rk_sel <= r_round;
                end
                ST_FIN: begin
                    r_dec  <= r_state;
                    r_done <= 1'b1;
                    r_full <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the ciphertext buffer and working state are pure data and are left out of reset;
    // every read of them is qualified by full or by the FSM having loaded them first.
    always_ff @(posedge clk) begin
        if (w_ct_wr) begin
            r_ct[{r_wr_ptr, 2'd0}] <= data_in[31:24];
            r_ct[{r_wr_ptr, 2'd1}] <= data_in[23:16];
            r_ct[{r_wr_ptr, 2'd2}] <= data_in[15:8];
            r_ct[{r_wr_ptr, 2'd3}] <= data_in[7:0];
        end
        case (r_st)
            ST_IDLE:   if (w_accept) r_state <= r_ct;
            ST_ARK:    r_state <= r_state ^ rk_data;
            ST_IMIX:   r_state <= inv_mix_columns(r_state);
            ST_ISHIFT: r_state <= inv_shift_rows(r_state);
            ST_ISUB:   r_state[r_cnt] <= w_sub_out;
            default: ;
        endcase
    end

    aes_inv_sbox u_inv_sbox (
        .i_byte (r_state[r_cnt]),
        .o_byte (w_sub_out)
    );

`ifdef AES_DEC_ERR_EN
    logic r_err;

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_err <= 1'b0;
        end else if (req_axi_in & ~w_idle) begin
            r_err <= 1'b1;
        end else if (w_ctl_wr) begin
            if (data_in[2])              r_err <= 1'b0;
            if (data_in[0] & ~r_full)    r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

    assign busy    = ~w_idle;
    assign done    = r_done;
    assign rk_sel  = r_rk_sel;
    assign decData = r_dec;

endmodule

// File: tb/tb_aes256_dec_core.sv
// Self-checking bench for aes256_dec_core: key ROM from an AES-256 key expansion,
// expected plaintexts from an independent forward (encryption) model, scoreboard queue.
module tb_aes256_dec_core;

    typedef logic [15:0][7:0] blk_t;
    typedef struct { logic [127:0] pt; int t0; } exp_t;
    typedef struct { int v; int t; } rk_ev_t;

    logic         clk;
    logic         resetn;
    logic         addr;
    logic [31:0]  data_in;
    logic         req_axi_in;
    logic [3:0]   rk_sel;
    logic [127:0] rk_data;
    logic         busy;
    logic         done;
    logic [127:0] decData;
`ifdef AES_DEC_ERR_EN
    logic         err;
`endif

    aes256_dec_core dut (
        .clk        (clk),
        .resetn     (resetn),
        .addr       (addr),
        .data_in    (data_in),
        .req_axi_in (req_axi_in),
        .rk_sel     (rk_sel),
        .rk_data    (rk_data),
        .busy       (busy),
        .done       (done),
`ifdef AES_DEC_ERR_EN
        .err        (err),
`endif
        .decData    (decData)
    );

    logic [7:0]   sbox [0:255];
    logic [127:0] rom  [0:14];
    exp_t         exp_q [$];
    rk_ev_t       rk_log [$];
    exp_t         mon_e;
    rk_ev_t       mon_ev;
    logic [3:0]   last_rk = 4'd0;
    int           cyc = 0;
    int           run_t0 = 0;
    int           n_checks = 0;
    int           n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Key ROM answers one cycle after rk_sel changes.
    always @(posedge clk) rk_data <= rom[rk_sel];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xt(x);
        end
        return acc;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic blk_t from_be(input logic [127:0] be);
        blk_t b;
        for (int i = 0; i < 16; i++) b[i] = be[127-8*i -: 8];
        return b;
    endfunction

    function automatic logic [31:0] wd(input blk_t b, input int p);
        return {b[4*p], b[4*p+1], b[4*p+2], b[4*p+3]};
    endfunction

    task automatic build_model();
        logic [7:0]  inv;
        logic [7:0]  b;
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rcon;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
        for (int i = 0; i < 8; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        rcon = 8'h01;
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 4; c++)
                for (int k = 0; k < 4; k++)
                    rom[r][8*(4*c+k) +: 8] = w[4*r+c][31-8*k -: 8];
    endtask

    function automatic blk_t aes_enc(input blk_t p);
        blk_t       s;
        blk_t       t;
        logic [7:0] a0, a1, a2, a3;
        s = p ^ rom[0];
        for (int r = 1; r <= 14; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int k = 0; k < 4; k++)
                    t[4*c+k] = s[4*((c+k)%4)+k];
            s = t;
            if (r < 14) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            s = s ^ rom[r];
        end
        return s;
    endfunction

    // ---------------- bus tasks ----------------
    task automatic bus_wr(input logic a, input logic [31:0] d);
        @(negedge clk);
        addr = a; data_in = d; req_axi_in = 1'b1;
        @(negedge clk);
        req_axi_in = 1'b0;
    endtask

    task automatic load_ct(input blk_t c);
        for (int p = 0; p < 4; p++) bus_wr(1'b1, wd(c, p));
    endtask

    task automatic start_run(input logic [127:0] pt, input bit accept);
        exp_t e;
        @(negedge clk);
        addr = 1'b0; data_in = 32'h1; req_axi_in = 1'b1;
        if (accept) begin
            e.pt = pt;
            e.t0 = cyc + 1;
            exp_q.push_back(e);
            run_t0 = cyc + 1;
        end
        @(negedge clk);
        req_axi_in = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy === 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_timeout"}, 128'(busy), 128'd0);
        repeat (3) @(negedge clk);
        check({tag, "_sb"}, 128'(exp_q.size()), 128'd0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (resetn === 1'b0 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("done_unexpected", 128'(done), 128'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("decData", decData, mon_e.pt);
                check("done_latency", 128'(cyc - mon_e.t0), 128'd282);
            end
        end
        if (rk_sel !== last_rk) begin
            mon_ev.v = int'(rk_sel);
            mon_ev.t = cyc - run_t0;
            rk_log.push_back(mon_ev);
            last_rk = rk_sel;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        blk_t ct1, pt1, p, c;
        int   exp_t_rk;
        resetn = 1'b1; addr = 1'b0; data_in = 32'h0; req_axi_in = 1'b0;
        build_model();
        ct1 = from_be(128'h8ea2b7ca516745bfeafc49904b496089);
        pt1 = from_be(128'h00112233445566778899aabbccddeeff);
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_decData", decData, 128'd0);
        check("rst_rk_sel", 128'(rk_sel), 128'd0);
`ifdef AES_DEC_ERR_EN
        check("rst_err", 128'(err), 128'd0);
`endif

        // Test 1 + 5: FIPS-197 C.3 vector, rk_sel sequence and timing
        load_ct(ct1);
        rk_log.delete();
        start_run(pt1, 1'b1);
        check("t1_busy", 128'(busy), 128'd1);
        wait_idle("t1");
        check("t5_rk_count", 128'(rk_log.size()), 128'd15);
        for (int k = 0; k < 15 && k < rk_log.size(); k++) begin
            exp_t_rk = (k == 0) ? 0 : 19 + (k - 1) * 20;
            check("t5_rk_val", 128'(rk_log[k].v), 128'(14 - k));
            check("t5_rk_time", 128'(rk_log[k].t), 128'(exp_t_rk));
        end

        // Test 2: start with only three words is ignored
        bus_wr(1'b0, 32'h2);
        for (int q = 0; q < 3; q++) bus_wr(1'b1, wd(ct1, q));
        start_run(pt1, 1'b0);
        repeat (4) @(negedge clk);
        check("t2_not_busy", 128'(busy), 128'd0);
        bus_wr(1'b1, wd(ct1, 3));
        start_run(pt1, 1'b1);
        wait_idle("t2");

        // Test 3: writes while busy are ignored
`ifdef AES_DEC_ERR_EN
        bus_wr(1'b0, 32'h4);
        check("t3_err_clear0", 128'(err), 128'd0);
`endif
        load_ct(ct1);
        start_run(pt1, 1'b1);
        repeat (50) @(negedge clk);
        bus_wr(1'b1, 32'hdeadbeef);
        bus_wr(1'b0, 32'h1);
`ifdef AES_DEC_ERR_EN
        check("t3_err_set", 128'(err), 128'd1);
`endif
        wait_idle("t3");
`ifdef AES_DEC_ERR_EN
        check("t3_err_sticky", 128'(err), 128'd1);
        bus_wr(1'b0, 32'h4);
        check("t3_err_clear", 128'(err), 128'd0);
`endif
        p = {$urandom, $urandom, $urandom, $urandom};
        load_ct(aes_enc(p));
        start_run(p, 1'b1);
        wait_idle("t3_ptr");

        // Test 4: reset in the middle of a run
        load_ct(ct1);
        start_run(pt1, 1'b1);
        repeat (100) @(negedge clk);
        exp_q.delete();
        resetn = 1'b1;
        #1;
        check("t4_busy", 128'(busy), 128'd0);
        check("t4_decData", decData, 128'd0);
        check("t4_done", 128'(done), 128'd0);
        check("t4_rk_sel", 128'(rk_sel), 128'd0);
        @(negedge clk);
        resetn = 1'b0;
        start_run(pt1, 1'b0);
        repeat (3) @(negedge clk);
        check("t4_start_no_full", 128'(busy), 128'd0);
        load_ct(ct1);
        start_run(pt1, 1'b1);
        wait_idle("t4");

        // Test 6: fifth word overwrites word 0
        for (int it = 0; it < 2; it++) begin
            p = {$urandom, $urandom, $urandom, $urandom};
            c = aes_enc(p);
            bus_wr(1'b0, 32'h2);
            bus_wr(1'b1, $urandom);
            for (int q = 1; q < 4; q++) bus_wr(1'b1, wd(c, q));
            bus_wr(1'b1, wd(c, 0));
            start_run(p, 1'b1);
            wait_idle("t6");
        end

        // Start together with clr_ptr is ignored and empties the buffer
        load_ct(ct1);
        bus_wr(1'b0, 32'h3);
        repeat (2) @(negedge clk);
        check("t7_start_clr", 128'(busy), 128'd0);
        start_run(pt1, 1'b0);
        repeat (2) @(negedge clk);
        check("t7_after_clr", 128'(busy), 128'd0);
        check("t7_decData_hold", decData, 128'(p));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
